// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the fifo write-side arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  // Wide enough to hold a beat count up to the largest supported BURST (16).
  localparam int BCNT_W = 5;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake plus fifo write-port bundle; the arbiter takes the slave side.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_din;
  logic               fifo_full;
  logic [NREQ-1:0]    grant;
  logic               busy;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr, fifo_din, grant, busy
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr, fifo_din, grant, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx
);

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    // Walk from farthest to nearest so the nearest candidate after 'last' is the one kept.
    for (int k = N; k >= 1; k--) begin
      int j;
      j = (int'(last) + k) % N;
      if (req[j]) begin
        win_oh    = '0;
        win_oh[j] = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one fifo write port among NREQ producers.
// Optional per-requester accepted-word counters behind FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_wr_arbiter_if.slave     bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]   stat_words
`endif
);

  localparam int IW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);

  arb_state_e        state;
  logic [NREQ-1:0]   grant_q;
  logic              busy_q;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     last_owner;
  logic [BCNT_W-1:0] beats;

  logic [NREQ-1:0]   pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              in_grant;
  logic              own_vld;
  logic              xfer;
  logic              last_beat;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req     (bus.req_valid),
    .last    (last_owner),
    .win_oh  (pick_oh),
    .win_idx (pick_idx)
  );

  assign in_grant  = (state == ARB_GRANT);
  assign own_vld   = bus.req_valid[owner];
  // rst gates the write so a word offered on the reset edge is dropped, not half-accepted.
  assign xfer      = in_grant & own_vld & ~bus.fifo_full & ~rst;
  assign last_beat = (beats == BCNT_W'(BURST - 1));

  assign bus.fifo_wr   = xfer;
  assign bus.req_ready = (in_grant && !bus.fifo_full && !rst) ? grant_q : '0;
  assign bus.fifo_din  = in_grant ? bus.req_data[int'(owner)*DW +: DW] : '0;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      owner      <= '0;
      last_owner <= IW'(NREQ - 1);
      beats      <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|bus.req_valid) begin
            state   <= ARB_GRANT;
            grant_q <= pick_oh;
            busy_q  <= 1'b1;
            owner   <= pick_idx;
            beats   <= '0;
          end
        end
        ARB_GRANT: begin
          if (!own_vld || (xfer && last_beat)) begin
            state      <= ARB_IDLE;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            last_owner <= owner;
            beats      <= '0;
          end else if (xfer) begin
            beats <= beats + BCNT_W'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
      if (rst)
        cnt <= '0;
      else if (xfer && grant_q[i] && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
    end
    assign stat_words[i*16 +: 16] = cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized bench for fifo_wr_arbiter against an 8-deep fifo model and burst-order reference.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_words;
`endif

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_words (stat_words)
`endif
  );

  logic [DW-1:0]   src_mem [NREQ][64];
  int              src_hd [NREQ];
  int              src_tl [NREQ];
  int              acc [NREQ];
  logic [DW-1:0]   fq[$];
  logic [DW-1:0]   wlog[$];
  logic [DW-1:0]   expq[$];
  int              wcyc[$];
  logic [NREQ-1:0] glog[$];
  int              segs[$];
  int              lens[$];
  int              gaps[$];
  int              n_cmp, n_err, cyc, zr;
  logic [NREQ-1:0] pg;
  logic            s_wr, s_busy;
  logic [DW-1:0]   s_din;
  logic [NREQ-1:0] s_grant, s_ready;
  int              exp_seg [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < NREQ; i++) if (src_hd[i] != src_tl[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int i, input logic [DW-1:0] d);
    src_mem[i][src_tl[i]] = d;
    src_tl[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = (src_hd[i] != src_tl[i]);
      bus.req_data[i*DW +: DW] = bus.req_valid[i] ? src_mem[i][src_hd[i]] : '0;
    end
    bus.fifo_full = (fq.size() >= DEPTH);
  endtask

  task automatic look();
    #1;
    s_wr = bus.fifo_wr; s_din = bus.fifo_din; s_grant = bus.grant;
    s_ready = bus.req_ready; s_busy = bus.busy;
  endtask

  // One clock: sample, let the edge happen, update fifo/producer models, re-drive at negedge.
  task automatic step(input bit rd);
    look();
    if (s_wr) chk("no_wr_when_full", bus.fifo_full, 0);
    glog.push_back(s_grant);
    @(posedge clk);
    if (rd && fq.size() > 0) void'(fq.pop_front());
    if (s_wr) begin fq.push_back(s_din); wlog.push_back(s_din); wcyc.push_back(cyc); end
    for (int i = 0; i < NREQ; i++)
      if (bus.req_valid[i] && s_ready[i]) begin src_hd[i]++; acc[i]++; end
    cyc++;
    @(negedge clk);
    drive();
  endtask

  task automatic clear_logs();
    wlog.delete(); wcyc.delete(); glog.delete(); expq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin src_hd[i] = 0; src_tl[i] = 0; end
    fq.delete();
    drive();
    step(0); step(0);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) acc[i] = 0;
    clear_logs();
  endtask

  task automatic chk_idle(input string tag);
    look();
    chk({tag, "_grant"}, s_grant, 0);
    chk({tag, "_busy"},  s_busy,  0);
    chk({tag, "_ready"}, s_ready, 0);
    chk({tag, "_wr"},    s_wr,    0);
    chk({tag, "_din"},   s_din,   0);
  endtask

  task automatic wait_grant(input string tag, input logic [NREQ-1:0] exp);
    int n;
    n = 0;
    look();
    while (s_grant == 0 && n < 20) begin step(1); look(); n++; end
    chk(tag, s_grant, exp);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    look();
    while (s_busy && n < 40) begin step(1); look(); n++; end
    chk(tag, s_busy, 0);
  endtask

  task automatic drain(input string tag, input int bound, input bit rnd);
    int n;
    bit rd;
    n = 0;
    look();
    while ((s_busy || !src_empty()) && n < bound) begin
      rd = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      step(rd); look(); n++;
    end
    chk(tag, (s_busy || !src_empty()), 0);
  endtask

  // Reference: bursts of up to BURST words, owners chosen round-robin among requesters with words left.
  task automatic build_exp();
    int rem [NREQ];
    int pos [NREQ];
    int p, j, n;
    bit any;
    expq.delete();
    for (int i = 0; i < NREQ; i++) begin rem[i] = src_tl[i] - src_hd[i]; pos[i] = src_hd[i]; end
    p = NREQ - 1;
    any = 1'b1;
    while (any) begin
      any = 1'b0; j = 0;
      for (int k = 1; k <= NREQ; k++)
        if (!any && rem[(p + k) % NREQ] > 0) begin any = 1'b1; j = (p + k) % NREQ; end
      if (any) begin
        n = (rem[j] < BURST) ? rem[j] : BURST;
        for (int m = 0; m < n; m++) expq.push_back(src_mem[j][pos[j] + m]);
        pos[j] += n; rem[j] -= n; p = j;
      end
    end
  endtask

  task automatic cmp_words(input string tag);
    chk({tag, "_count"}, wlog.size(), expq.size());
    for (int k = 0; k < wlog.size() && k < expq.size(); k++) chk(tag, wlog[k], expq[k]);
  endtask

  task automatic chk_stats(input string tag);
`ifdef FIFO_WR_ARB_STATS_EN
    look();
    for (int i = 0; i < NREQ; i++) chk(tag, 32'(stat_words[i*16 +: 16]), acc[i]);
`else
    look();
    chk(tag, s_busy, 0);
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; rst = 1'b1;
    bus.req_valid = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
    @(negedge clk);
    do_reset();
    rst = 1'b1; step(0); look();
    chk_idle("reset");
    rst = 1'b0;

    // Single requester, one full burst.
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
    drive(); look();
    chk("s1_pre_grant", s_grant, 0);
    step(0); look();
    chk("s1_grant", s_grant, 4'b0001);
    chk("s1_first_din", s_din, 8'h11);
    repeat (4) step(0);
    look();
    chk("s1_back_idle", s_busy, 0);
    expq = '{8'h11, 8'h22, 8'h33, 8'h44};
    cmp_words("s1_words");
    if (wcyc.size() == 4) chk("s1_consecutive", wcyc[3] - wcyc[0], 3);

    // All four continuously valid: order 0,1,2,3,0 with one bubble between grants.
    do_reset();
    for (int k = 0; k < 8; k++) push(0, 8'(k));
    for (int i = 1; i < NREQ; i++) for (int k = 0; k < 4; k++) push(i, 8'((i << 4) + k));
    drive(); build_exp();
    drain("s2_drain", 80, 0);
    cmp_words("s2_words");
    pg = '0; zr = 0; segs.delete(); lens.delete(); gaps.delete();
    foreach (glog[c]) begin
      if (glog[c] == 0) zr++;
      else if (glog[c] != pg) begin
        if (segs.size() > 0) gaps.push_back(zr);
        segs.push_back(int'(glog[c])); lens.push_back(1); zr = 0;
      end else lens[lens.size()-1]++;
      pg = glog[c];
    end
    exp_seg = '{1, 2, 4, 8, 1};
    chk("s2_nseg", segs.size(), 5);
    for (int s = 0; s < segs.size() && s < 5; s++) begin
      chk("s2_order", segs[s], exp_seg[s]);
      chk("s2_len", lens[s], BURST);
    end
    foreach (gaps[g]) chk("s2_bubble", gaps[g], 1);

    // Fifo fills mid-burst; grant and count held until a read frees a slot.
    do_reset();
    repeat (5) fq.push_back(8'hEE);
    push(0, 8'hA0); push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
    drive();
    repeat (4) step(0);
    look();
    chk("s3_full", bus.fifo_full, 1);
    chk("s3_stall_wr", s_wr, 0);
    chk("s3_stall_ready", s_ready, 0);
    repeat (3) step(0);
    look();
    chk("s3_hold_grant", s_grant, 4'b0001);
    chk("s3_hold_wr", s_wr, 0);
    step(1); look();
    chk("s3_resume_wr", s_wr, 1);
    chk("s3_resume_din", s_din, 8'hA3);
    step(0); look();
    chk("s3_release", s_busy, 0);
    expq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    cmp_words("s3_words");

    // Owner drops valid after two words; next pick wraps to 0 or takes 3 when valid.
    do_reset();
    for (int v = 0; v < 2; v++) begin
      push(1, 8'h51); push(2, 8'h61); push(2, 8'h62);
      drive();
      wait_grant("s4_first", 4'b0010);
      wait_idle("s4_first_done");
      wait_grant("s4_owner2", 4'b0100);
      push(0, 8'h01);
      if (v == 1) push(3, 8'h71);
      drive();
      step(1); step(1); look();
      chk("s4_drop_grant", s_grant, 4'b0100);
      chk("s4_drop_wr", s_wr, 0);
      step(1); look();
      chk("s4_release", s_busy, 0);
      wait_grant(v == 1 ? "s4_next3" : "s4_wrap0", v == 1 ? 4'b1000 : 4'b0001);
      wait_idle("s4_done");
    end

    // Reset on requester 1's third word.
    do_reset();
    push(1, 8'h91); push(1, 8'h92); push(1, 8'h93); push(1, 8'h94);
    drive();
    wait_grant("s5_grant", 4'b0010);
    step(1); step(1); look();
    chk("s5_third_din", s_din, 8'h93);
    rst = 1'b1; look();
    chk("s5_wr_in_rst", s_wr, 0);
    step(1);
    chk_idle("s5_after_rst");
    chk("s5_written", wlog.size(), 2);
    rst = 1'b0;
    push(0, 8'h01); drive();
    wait_grant("s5_next", 4'b0001);

    // Randomized contents and fifo drain rate against the burst-order reference.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
        int n;
        n = $urandom_range(0, 10);
        for (int k = 0; k < n; k++) push(i, 8'($urandom_range(0, 255)));
      end
      drive(); build_exp();
      drain("rnd_drain", 1500, 1);
      cmp_words("rnd_words");
      chk_stats("stat_words");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one 8-deep `fifo` write port between NREQ producers. Each producer offers words on a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to BURST words and drives the FIFO's `wr`/`din` inputs. It honours `full` so that no write is ever issued into a full FIFO. It sits directly in front of the `fifo` write side; the read side is untouched.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width; matches `fifo` din
- BURST, 4, maximum words per grant (1..16)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester word available
- req_data  in  NREQ*DW  requester i word at bits [i*DW +: DW]
- req_ready  out  NREQ  word of requester i accepted this cycle when valid&ready
- fifo_wr  out  1  to `fifo.wr`
- fifo_din  out  DW  to `fifo.din`
- fifo_full  in  1  from `fifo.full`
- grant  out  NREQ  one-hot current owner; all-zero when idle
- busy  out  1  high while in GRANT

## Operation
- States: IDLE, GRANT (2-state FSM, registered).
- IDLE
  - If any req_valid is high, pick the first valid index searching from last_owner+1 upward with wrap.
  - Register grant and owner and clear the beat counter, then go to GRANT.
  - If no request, stay in IDLE.
- GRANT, owner g
  - req_ready[g] = ~fifo_full; all other req_ready bits are 0.
  - Transfer = req_valid[g] & ~fifo_full.
  - fifo_wr = transfer.
  - fifo_din = req_data slice g (combinational, same cycle).
  - The beat counter increments on each transfer.
- Release (go to IDLE, set last_owner = g):
  - after the transfer that brings the count to BURST; or
  - in any cycle where req_valid[g] = 0.
- fifo_full high: hold the grant and do not advance the counter. Stall indefinitely; no timeout.
- Non-owners are never acknowledged, and their valid bits are ignored until the next arbitration.
- Simultaneous release and a new request: the new request is arbitrated in the following IDLE cycle.
- Wrap-around: the pointer search is modulo NREQ. An owner at index NREQ-1 hands priority to index 0.
- Fairness: a requester that is continuously valid is granted within NREQ-1 intervening grants.

## Timing
- Reset values:
  - state = IDLE
  - grant = 0
  - busy = 0
  - req_ready = 0
  - fifo_wr = 0
  - fifo_din = 0
  - beat counter = 0
  - last_owner = NREQ-1, so index 0 has first priority
- Arbitration latency: req_valid high in IDLE at edge n gives grant visible after edge n. The first word is written at edge n+1 if the FIFO is not full.
- One idle bubble cycle between consecutive grants.
- Peak throughput: BURST words per BURST+1 cycles.
- rst asserted mid-burst: all state returns to reset values at that edge. A word presented in the same cycle is not written (fifo_wr is forced 0 while rst is high).

## Configuration
- Macro: `FIFO_WR_ARB_STATS_EN`.
- Defined:
  - adds output `stat_words`, NREQ*16 bits.
  - one 16-bit counter per requester, incremented on each accepted word.
  - counters saturate at 0xFFFF and clear on rst.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

## Structure
- Package `fifo_arb_pkg` holds:
  - state typedef (ARB_IDLE, ARB_GRANT)
  - localparam for BURST counter width
  - function clog2 for the owner-index width
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are the request vector and last_owner; outputs are the one-hot winner and its index. It is reusable by the planned read-side scheduler.

## Test plan
- Single requester, after reset: req 0 presents 11, 22, 33, 44 with valid continuously high, BURST = 4.
  - grant = 0001 one cycle after valid.
  - FIFO receives 11, 22, 33, 44 on consecutive edges.
  - Then the block returns to IDLE.
- All 4 requesters valid continuously, each with a distinct tag:
  - grant order is 0, 1, 2, 3, 0.
  - each grant writes exactly 4 words.
  - one bubble cycle between grants.
- FIFO fills mid-burst: the 8th word total sets full.
  - fifo_wr stays 0 and the grant and counter are held.
  - After one read, the remaining word is written.
  - No write ever occurs while full = 1.
- Requester 2 drops valid after 2 words:
  - grant releases that cycle.
  - next grant goes to index 3 if valid, otherwise wraps to 0.
- rst pulsed during requester 1's 3rd word:
  - no write on the reset edge.
  - all outputs return to 0.
  - the next grant goes to index 0.
- With `FIFO_WR_ARB_STATS_EN`: after the scenarios above, each stat_words slice equals that requester's accepted-word count.
